hall_call_latch: RTL and testbench

- Upstream front-end for the elevator controller: takes raw hall-call push-buttons (up/down per floor), synchronises and debounces them, and latches each accepted press as a pending request.
- Drives the upreq/downreq vectors consumed by the request resolver.
- Watches the car's current floor and door-open indication and clears requests once the car services that floor.

---
 rtl/hall_call_latch_if.sv | 32 +++
 rtl/hall_call_latch.sv | 149 ++++++++++++++
 tb/tb_hall_call_latch.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hall_call_latch_if.sv
// rtl/hall_call_latch_if.sv - hall-call front-end signal bundle
// Purpose: groups the hall button inputs, car position/door status and the
//          latched request outputs of hall_call_latch.
// Signals:
//   up_btn, down_btn  raw asynchronous hall buttons, bit i is floor i
//   floor, open       current car floor and door-open indication
//   upreq, downreq    latched pending requests (registered)
//   pending_cnt       population count of upreq plus downreq
// Modports: master drives buttons/floor/open, slave is the latch itself.
interface hall_call_latch_if #(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_BITS = $clog2(NUM_FLOORS),
  parameter int CNT_BITS   = $clog2(2*NUM_FLOORS+1)
);
  logic [NUM_FLOORS-1:0] up_btn;
  logic [NUM_FLOORS-1:0] down_btn;
  logic [FLOOR_BITS-1:0] floor;
  logic                  open;
  logic [NUM_FLOORS-1:0] upreq;
  logic [NUM_FLOORS-1:0] downreq;
  logic [CNT_BITS-1:0]   pending_cnt;

  modport master (
    output up_btn, down_btn, floor, open,
    input  upreq, downreq, pending_cnt
  );

  modport slave (
    input  up_btn, down_btn, floor, open,
    output upreq, downreq, pending_cnt
  );
endinterface

// File: rtl/hall_call_latch.sv
// rtl/hall_call_latch.sv - synchronise, debounce and latch hall calls
// Purpose: every hall button goes through a 2-flop synchroniser and a
//          debounce FSM; an accepted press latches a pending request that is
//          cleared when the car stands at that floor with doors open.
// Ports:
//   clk     system clock, rising edge
//   resetN  asynchronous active-low reset
//   bus     hall_call_latch_if.slave (buttons, floor, open, upreq, downreq,
//           pending_cnt)
// Option: define HALL_CALL_CANCEL_EN to make a press on a pending call
//         cancel it (toggle); undefined, such a press is ignored.
module hall_call_latch #(
  parameter int NUM_FLOORS      = 10,
  parameter int FLOOR_BITS      = $clog2(NUM_FLOORS),
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_BITS        = $clog2(2*NUM_FLOORS+1)
) (
  input logic             clk,
  input logic             resetN,
  hall_call_latch_if.slave bus
);
  // Bits 0..NUM_FLOORS-1 are up buttons, NUM_FLOORS..2*NUM_FLOORS-1 are down.
  localparam int NB = 2*NUM_FLOORS;
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES-1);

  typedef enum logic [1:0] {IDLE, PRESS_CNT, HELD, REL_CNT} state_t;

  logic [NB-1:0] sync1_q, sync2_q;
  state_t        state_q [NB];
  state_t        state_d [NB];
  logic [7:0]    cnt_q   [NB];
  logic [7:0]    cnt_d   [NB];
  logic [NB-1:0] press;
  logic [NB-1:0] clr;
  logic [NB-1:0] valid_mask;
  logic [NB-1:0] pend_q, pend_d;
  logic [CNT_BITS-1:0] pop;

  // No up call from the top floor, no down call from the ground floor.
  always_comb begin
    valid_mask                 = '1;
    valid_mask[NUM_FLOORS-1]   = 1'b0;
    valid_mask[NUM_FLOORS]     = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      press[i]   = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[i] = HELD;
              cnt_d[i]   = 8'd0;
              press[i]   = 1'b1;
            end else begin
              state_d[i] = PRESS_CNT;
              cnt_d[i]   = 8'd1;
            end
          end
        end
        PRESS_CNT: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = 8'd0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = 8'd0;
            press[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            // A single stable sample is already a complete release when
            // DEBOUNCE_CYCLES is 1.
            state_d[i] = (DEBOUNCE_CYCLES == 1) ? IDLE : REL_CNT;
            cnt_d[i]   = (DEBOUNCE_CYCLES == 1) ? 8'd0 : 8'd1;
          end
        end
        REL_CNT: begin
          if (sync2_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = 8'd0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = 8'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = 8'd0;
        end
      endcase
    end
  end

  // Service clear dominates any press event landing on the same edge; an
  // out-of-range floor simply matches no bit.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      clr[i]    = bus.open && (int'(bus.floor) == (i % NUM_FLOORS));
      pend_d[i] = pend_q[i];
      if (press[i]) begin
`ifdef HALL_CALL_CANCEL_EN
        pend_d[i] = ~pend_q[i];
`else
        pend_d[i] = 1'b1;
`endif
      end
      if (clr[i]) pend_d[i] = 1'b0;
    end
    pend_d = pend_d & valid_mask;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pend_q  <= '0;
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= 8'd0;
      end
    end else begin
      sync1_q <= {bus.down_btn, bus.up_btn};
      sync2_q <= sync1_q;
      pend_q  <= pend_d;
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NB; i++) pop = pop + CNT_BITS'(pend_q[i]);
  end

  assign bus.upreq       = pend_q[NUM_FLOORS-1:0];
  assign bus.downreq     = pend_q[NB-1:NUM_FLOORS];
  assign bus.pending_cnt = pop;
endmodule

// File: tb/tb_hall_call_latch.sv
// tb/tb_hall_call_latch.sv - directed self-checking bench for hall_call_latch
module tb_hall_call_latch;
  logic clk;
  logic resetN;
  int   checks;
  int   failures;

  hall_call_latch_if #(.NUM_FLOORS(10)) bus ();

  hall_call_latch #(.NUM_FLOORS(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_release(input logic [9:0] um, input logic [9:0] dm);
    bus.up_btn   = um;
    bus.down_btn = dm;
    tick(10);
    bus.up_btn   = '0;
    bus.down_btn = '0;
    tick(10);
  endtask

  task automatic service(input logic [3:0] f);
    bus.floor = f;
    bus.open  = 1'b1;
    tick(1);
    bus.open  = 1'b0;
  endtask

  task automatic test_reset;
    resetN       = 1'b0;
    bus.up_btn   = '0;
    bus.down_btn = '0;
    bus.floor    = '0;
    bus.open     = 1'b0;
    tick(3);
    checks++;
    if (bus.upreq !== 10'h000 || bus.downreq !== 10'h000 || bus.pending_cnt !== 5'd0) begin
      failures++;
      $display("FAIL reset: up=%h down=%h cnt=%0d, required 000 000 0",
               bus.upreq, bus.downreq, bus.pending_cnt);
    end
    resetN = 1'b1;
    tick(2);
  endtask

  task automatic test_latency_hold;
    logic [9:0] exp;
    bus.up_btn = 10'h008;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      exp = (e == 6) ? 10'h008 : 10'h000;
      checks++;
      if (bus.upreq !== exp) begin
        failures++;
        $display("FAIL latency edge %0d: upreq=%h, required %h", e, bus.upreq, exp);
      end
    end
    checks++;
    if (bus.pending_cnt !== 5'd1) begin
      failures++;
      $display("FAIL latency cnt: %0d, required 1", bus.pending_cnt);
    end
    for (int k = 0; k < 50; k++) begin
      tick(1);
      checks++;
      if (bus.upreq !== 10'h008 || bus.pending_cnt !== 5'd1) begin
        failures++;
        $display("FAIL hold cycle %0d: upreq=%h cnt=%0d, required 008 1",
                 k, bus.upreq, bus.pending_cnt);
      end
    end
    bus.up_btn = '0;
    tick(10);
    service(4'd3);
    checks++;
    if (bus.upreq !== 10'h000) begin
      failures++;
      $display("FAIL hold clear: upreq=%h, required 000", bus.upreq);
    end
  endtask

  task automatic test_glitch;
    bus.down_btn = 10'h020;
    tick(3);
    bus.down_btn = '0;
    tick(15);
    checks++;
    if (bus.downreq !== 10'h000 || bus.pending_cnt !== 5'd0) begin
      failures++;
      $display("FAIL glitch: downreq=%h cnt=%0d, required 000 0",
               bus.downreq, bus.pending_cnt);
    end
  endtask

  task automatic test_service_clear;
    press_release(10'h004, 10'h104);
    checks++;
    if (bus.upreq !== 10'h004 || bus.downreq !== 10'h104 || bus.pending_cnt !== 5'd3) begin
      failures++;
      $display("FAIL svc setup: up=%h down=%h cnt=%0d, required 004 104 3",
               bus.upreq, bus.downreq, bus.pending_cnt);
    end
    service(4'd12);
    checks++;
    if (bus.upreq !== 10'h004 || bus.downreq !== 10'h104 || bus.pending_cnt !== 5'd3) begin
      failures++;
      $display("FAIL svc out_of_range: up=%h down=%h cnt=%0d, required 004 104 3",
               bus.upreq, bus.downreq, bus.pending_cnt);
    end
    service(4'd2);
    checks++;
    if (bus.upreq !== 10'h000 || bus.downreq !== 10'h100 || bus.pending_cnt !== 5'd1) begin
      failures++;
      $display("FAIL svc floor2: up=%h down=%h cnt=%0d, required 000 100 1",
               bus.upreq, bus.downreq, bus.pending_cnt);
    end
    service(4'd8);
    checks++;
    if (bus.downreq !== 10'h000 || bus.pending_cnt !== 5'd0) begin
      failures++;
      $display("FAIL svc floor8: down=%h cnt=%0d, required 000 0",
               bus.downreq, bus.pending_cnt);
    end
  endtask

  task automatic test_invalid_buttons;
    bus.up_btn   = 10'h200;
    bus.down_btn = 10'h001;
    tick(20);
    checks++;
    if (bus.upreq !== 10'h000 || bus.downreq !== 10'h000 || bus.pending_cnt !== 5'd0) begin
      failures++;
      $display("FAIL invalid: up=%h down=%h cnt=%0d, required 000 000 0",
               bus.upreq, bus.downreq, bus.pending_cnt);
    end
    bus.up_btn   = '0;
    bus.down_btn = '0;
    tick(10);
  endtask

  task automatic test_clear_wins;
    bus.floor  = 4'd4;
    bus.up_btn = 10'h010;
    tick(5);
    checks++;
    if (bus.upreq !== 10'h000) begin
      failures++;
      $display("FAIL clrwin pre: upreq=%h, required 000", bus.upreq);
    end
    bus.open = 1'b1;
    tick(1);
    bus.open = 1'b0;
    checks++;
    if (bus.upreq !== 10'h000) begin
      failures++;
      $display("FAIL clrwin edge: upreq=%h, required 000", bus.upreq);
    end
    tick(10);
    checks++;
    if (bus.upreq !== 10'h000) begin
      failures++;
      $display("FAIL clrwin no_relatch: upreq=%h, required 000", bus.upreq);
    end
    bus.up_btn = '0;
    tick(10);
    bus.up_btn = 10'h010;
    tick(10);
    checks++;
    if (bus.upreq !== 10'h010 || bus.pending_cnt !== 5'd1) begin
      failures++;
      $display("FAIL clrwin repress: upreq=%h cnt=%0d, required 010 1",
               bus.upreq, bus.pending_cnt);
    end
    bus.up_btn = '0;
    tick(10);
    service(4'd4);
  endtask

  task automatic test_cancel;
    logic [9:0] exp;
    press_release(10'h040, 10'h000);
    checks++;
    if (bus.upreq !== 10'h040) begin
      failures++;
      $display("FAIL cancel setup: upreq=%h, required 040", bus.upreq);
    end
    press_release(10'h040, 10'h000);
`ifdef HALL_CALL_CANCEL_EN
    exp = 10'h000;
`else
    exp = 10'h040;
`endif
    checks++;
    if (bus.upreq !== exp) begin
      failures++;
      $display("FAIL cancel second_press: upreq=%h, required %h", bus.upreq, exp);
    end
    service(4'd6);
  endtask

  task automatic test_async_reset;
    press_release(10'h000, 10'h008);
    bus.up_btn = 10'h002;
    tick(4);
    #3;
    resetN = 1'b0;
    #1;
    checks++;
    if (bus.upreq !== 10'h000 || bus.downreq !== 10'h000 || bus.pending_cnt !== 5'd0) begin
      failures++;
      $display("FAIL async_reset: up=%h down=%h cnt=%0d, required 000 000 0",
               bus.upreq, bus.downreq, bus.pending_cnt);
    end
    tick(2);
    resetN = 1'b1;
    // Button still held: FSM restarts from IDLE, so full latency applies.
    tick(5);
    checks++;
    if (bus.upreq !== 10'h000) begin
      failures++;
      $display("FAIL async_reset restart_early: upreq=%h, required 000", bus.upreq);
    end
    tick(1);
    checks++;
    if (bus.upreq !== 10'h002 || bus.pending_cnt !== 5'd1) begin
      failures++;
      $display("FAIL async_reset restart: upreq=%h cnt=%0d, required 002 1",
               bus.upreq, bus.pending_cnt);
    end
    bus.up_btn = '0;
    tick(10);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetN   = 1'b0;
    test_reset();
    test_latency_hold();
    test_glitch();
    test_service_clear();
    test_invalid_buttons();
    test_clear_wins();
    test_cancel();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
